// File: rtl/filter_stream_tx_if.sv
// Stream bundle for filter_stream_tx: upstream ready/valid source and the
// tagged output stream into the filter control unit.
interface filter_stream_tx_if #(
  parameter int unsigned DATA_BIT   = 15,
  parameter int unsigned DATA_IDBIT = 2
);
  logic                  src_valid;
  logic [DATA_BIT-1:0]   src_data;
  logic                  src_ready;
  logic [DATA_IDBIT-1:0] tx_data_id;
  logic                  tx_valid;
  logic [DATA_BIT-1:0]   tx_data;

  modport master (
    input  src_valid, src_data,
    output src_ready, tx_data_id, tx_valid, tx_data
  );

  modport slave (
    output src_valid, src_data,
    input  src_ready, tx_data_id, tx_valid, tx_data
  );
endinterface

// File: rtl/filter_stream_tx.sv
// Sequences coefficient bursts and pixel frames from an upstream source into
// the filter control unit, with a guaranteed idle cycle between bursts.
module filter_stream_tx #(
  parameter int unsigned DATA_BIT   = 15,
  parameter int unsigned DATA_IDBIT = 2,
  parameter int unsigned ROW_WIDTH  = 512,
  parameter int unsigned COL_WIDTH  = 512,
  parameter int unsigned MASK_WIDTH = 7,
  parameter int unsigned CNT_BIT    = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_cf,
  input  logic               start_frame,
  filter_stream_tx_if.master bus,
  output logic               busy,
  output logic               cf_done,
  output logic               frame_done,
  output logic               underrun
);

  localparam int unsigned CF_LAST = MASK_WIDTH * MASK_WIDTH - 1;
  localparam int unsigned X_LAST  = ROW_WIDTH - 1;
  localparam int unsigned Y_LAST  = COL_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CF_BURST  = 2'd1,
    PIX_BURST = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [CNT_BIT-1:0]    x_cnt, y_cnt, x_next, y_next;
  logic                  cf_done_next, frame_done_next, underrun_next;
  logic                  src_ready_c, accept_c;
  logic                  tx_valid_q;
  logic [DATA_BIT-1:0]   tx_data_q;
  logic [DATA_IDBIT-1:0] tx_id_q;

  // The control unit cannot stall, so readiness depends on state alone
  assign src_ready_c    = (state != IDLE);
  assign accept_c       = bus.src_valid & src_ready_c;
  assign bus.src_ready  = src_ready_c;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_data_id = tx_id_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state, counters and completion/abort flags
  always_comb begin
    state_next      = state;
    x_next          = x_cnt;
    y_next          = y_cnt;
    cf_done_next    = 1'b0;
    frame_done_next = 1'b0;
    underrun_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_cf) begin
          state_next = CF_BURST;
          x_next     = '0;
          y_next     = '0;
        end else if (start_frame) begin
          state_next = PIX_BURST;
          x_next     = '0;
          y_next     = '0;
        end
      end
      CF_BURST: begin
        if (!bus.src_valid) begin
          state_next    = IDLE;
          underrun_next = 1'b1;
        end else if (x_cnt == CNT_BIT'(CF_LAST)) begin
          state_next   = IDLE;
          cf_done_next = 1'b1;
        end else begin
          x_next = x_cnt + 1'b1;
        end
      end
      PIX_BURST: begin
        if (!bus.src_valid) begin
          state_next    = IDLE;
          underrun_next = 1'b1;
        end else if (x_cnt == CNT_BIT'(X_LAST)) begin
          x_next = '0;
          if (y_cnt == CNT_BIT'(Y_LAST)) begin
            state_next      = IDLE;
            frame_done_next = 1'b1;
          end else begin
            y_next = y_cnt + 1'b1;
          end
        end else begin
          x_next = x_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, output stage and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_id_q    <= '0;
      busy       <= 1'b0;
      cf_done    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      x_cnt      <= x_next;
      y_cnt      <= y_next;
      tx_valid_q <= accept_c;
      if (accept_c) tx_data_q <= bus.src_data;
      tx_id_q    <= (accept_c && state == CF_BURST) ? DATA_IDBIT'(1) : '0;
      busy       <= (state_next != IDLE);
      cf_done    <= cf_done_next;
      frame_done <= frame_done_next;
      underrun   <= underrun_next;
    end
  end

endmodule

// File: tb/tb_filter_stream_tx.sv
// Scoreboard bench for filter_stream_tx using an 8x4 frame and a 3x3 mask.
module tb_filter_stream_tx;

  localparam int unsigned DB   = 15;
  localparam int unsigned IDB  = 2;
  localparam int unsigned ROW  = 8;
  localparam int unsigned COL  = 4;
  localparam int unsigned MASK = 3;
  localparam int unsigned NPIX = ROW * COL;
  localparam int unsigned NCF  = MASK * MASK;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_cf = 1'b0;
  logic start_frame = 1'b0;
  logic busy, cf_done, frame_done, underrun;

  filter_stream_tx_if #(.DATA_BIT(DB), .DATA_IDBIT(IDB)) bus ();

  filter_stream_tx #(
    .DATA_BIT(DB), .DATA_IDBIT(IDB), .ROW_WIDTH(ROW), .COL_WIDTH(COL),
    .MASK_WIDTH(MASK), .CNT_BIT(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_cf(start_cf), .start_frame(start_frame),
    .bus(bus.master), .busy(busy), .cf_done(cf_done), .frame_done(frame_done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDB-1:0] id;
    logic [DB-1:0]  data;
    logic           last;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int tx_cnt = 0, cf_cnt = 0, fr_cnt = 0, un_cnt = 0, busy_cnt = 0;
  bit mon_en = 1'b0;

  // Scoreboard monitor: every tx word must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (cf_done) cf_cnt++;
      if (frame_done) fr_cnt++;
      if (underrun) un_cnt++;
      if (busy) busy_cnt++;
      if (bus.tx_valid) begin
        tx_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got id=%0d data=%0d, expected no word",
                   bus.tx_data_id, bus.tx_data);
        end else begin
          e = q.pop_front();
          if ({bus.tx_data_id, bus.tx_data, cf_done, frame_done} !==
              {e.id, e.data, e.last && (e.id == 1), e.last && (e.id == 0)}) begin
            errors++;
            $display("FAIL word: got id=%0d data=%0d cf_done=%0b frame_done=%0b, expected id=%0d data=%0d last=%0b",
                     bus.tx_data_id, bus.tx_data, cf_done, frame_done, e.id, e.data, e.last);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    tx_cnt = 0; cf_cnt = 0; fr_cnt = 0; un_cnt = 0; busy_cnt = 0;
  endtask

  task automatic push(input bit cf, input int data, input bit last);
    exp_t e;
    e.id   = cf ? IDB'(1) : '0;
    e.data = DB'(data);
    e.last = last;
    q.push_back(e);
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    reset_n = 1'b0; bus.src_valid = 1'b1; bus.src_data = DB'(5);
    start_cf = 1'b1; start_frame = 1'b1;
    repeat (3) step();
    obs = {bus.tx_valid, bus.tx_data, bus.tx_data_id, busy, cf_done, frame_done, underrun, bus.src_ready};
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_hold: got %h expected 0", obs);
    end
    start_cf = 1'b0; start_frame = 1'b0;
    reset_n = 1'b1;
    repeat (3) step();
    obs = {bus.tx_valid, bus.tx_data, bus.tx_data_id, busy, cf_done, frame_done, underrun, bus.src_ready};
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_release: got %h expected 0", obs);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_cf_burst();
    clear_counts();
    start_cf = 1'b1; bus.src_valid = 1'b1; bus.src_data = '0;
    step();
    start_cf = 1'b0;
    checks++;
    if ({busy, bus.src_ready, bus.tx_valid} !== 3'b110) begin
      errors++; $display("FAIL cf_start: got busy/ready/valid=%b expected 110", {busy, bus.src_ready, bus.tx_valid});
    end
    for (int k = 1; k <= int'(NCF); k++) begin
      bus.src_data = DB'(k);
      push(1'b1, k, k == int'(NCF));
      step();
      checks++;
      if (bus.tx_valid !== 1'b1) begin
        errors++; $display("FAIL cf_contiguous: word %0d tx_valid=%b expected 1", k, bus.tx_valid);
      end
    end
    bus.src_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cf_busy_end: got %b expected 0", busy);
    end
    repeat (3) step();
    checks++;
    if ({tx_cnt, cf_cnt, busy_cnt, un_cnt, q.size()} !== {32'(NCF), 32'd1, 32'(NCF), 32'd0, 32'd0}) begin
      errors++; $display("FAIL cf_totals: got tx=%0d cf_done=%0d busy=%0d underrun=%0d left=%0d expected %0d 1 %0d 0 0",
                         tx_cnt, cf_cnt, busy_cnt, un_cnt, q.size(), NCF, NCF);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    start_frame = 1'b1; bus.src_valid = 1'b1;
    step();
    start_frame = 1'b0;
    for (int k = 0; k < int'(NPIX); k++) begin
      bus.src_data = DB'(k);
      push(1'b0, k, k == int'(NPIX) - 1);
      step();
    end
    checks++;
    if ({frame_done, bus.tx_valid, busy} !== 3'b110) begin
      errors++; $display("FAIL frame_end: got done/valid/busy=%b expected 110", {frame_done, bus.tx_valid, busy});
    end
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    checks++;
    if ({bus.tx_valid, busy} !== 2'b01) begin
      errors++; $display("FAIL b2b_gap: got valid/busy=%b expected 01", {bus.tx_valid, busy});
    end
    for (int k = 0; k < int'(NPIX); k++) begin
      bus.src_data = DB'(100 + k);
      push(1'b0, 100 + k, k == int'(NPIX) - 1);
      step();
      if (k == 0) begin
        checks++;
        if (bus.tx_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_first: got tx_valid=%b expected 1", bus.tx_valid);
        end
      end
    end
    bus.src_valid = 1'b0;
    repeat (3) step();
    checks++;
    if ({tx_cnt, fr_cnt, un_cnt, q.size()} !== {32'(2 * NPIX), 32'd2, 32'd0, 32'd0}) begin
      errors++; $display("FAIL frame_totals: got tx=%0d frame_done=%0d underrun=%0d left=%0d expected %0d 2 0 0",
                         tx_cnt, fr_cnt, un_cnt, q.size(), 2 * NPIX);
    end
  endtask

  task automatic test_priority();
    clear_counts();
    start_cf = 1'b1; start_frame = 1'b1; bus.src_valid = 1'b1;
    step();
    start_cf = 1'b0; start_frame = 1'b0;
    for (int k = 1; k <= int'(NCF); k++) begin
      bus.src_data = DB'(200 + k);
      start_frame = (k == 4);
      push(1'b1, 200 + k, k == int'(NCF));
      step();
    end
    start_frame = 1'b0;
    repeat (4) step();
    bus.src_valid = 1'b0;
    checks++;
    if ({tx_cnt, cf_cnt, fr_cnt, busy_cnt, q.size()} !== {32'(NCF), 32'd1, 32'd0, 32'(NCF), 32'd0}) begin
      errors++; $display("FAIL priority: got tx=%0d cf_done=%0d frame_done=%0d busy=%0d left=%0d expected %0d 1 0 %0d 0",
                         tx_cnt, cf_cnt, fr_cnt, busy_cnt, q.size(), NCF, NCF);
    end
  endtask

  task automatic test_underrun();
    clear_counts();
    start_frame = 1'b1; bus.src_valid = 1'b1;
    step();
    start_frame = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.src_data = DB'(300 + k);
      push(1'b0, 300 + k, 1'b0);
      step();
    end
    bus.src_valid = 1'b0; bus.src_data = DB'(312);
    step();
    checks++;
    if ({bus.tx_valid, underrun, busy, bus.src_ready} !== 4'b0100) begin
      errors++; $display("FAIL underrun_cycle: got valid/underrun/busy/ready=%b expected 0100",
                         {bus.tx_valid, underrun, busy, bus.src_ready});
    end
    bus.src_valid = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.src_ready, busy} !== 2'b00) begin
      errors++; $display("FAIL underrun_idle: got ready/busy=%b expected 00", {bus.src_ready, busy});
    end
    bus.src_valid = 1'b0;
    checks++;
    if ({tx_cnt, un_cnt, fr_cnt, q.size()} !== {32'd12, 32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL underrun_totals: got tx=%0d underrun=%0d frame_done=%0d left=%0d expected 12 1 0 0",
                         tx_cnt, un_cnt, fr_cnt, q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    start_frame = 1'b1; bus.src_valid = 1'b1;
    step();
    start_frame = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.src_data = DB'(400 + k);
      push(1'b0, 400 + k, 1'b0);
      step();
    end
    bus.src_data = DB'(420);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_valid, busy, bus.src_ready} !== 3'b000) begin
      errors++; $display("FAIL async_reset: got valid/busy/ready=%b expected 000", {bus.tx_valid, busy, bus.src_ready});
    end
    repeat (2) step();
    reset_n = 1'b1;
    step();
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    for (int k = 0; k < int'(NPIX); k++) begin
      bus.src_data = DB'(500 + k);
      push(1'b0, 500 + k, k == int'(NPIX) - 1);
      step();
    end
    bus.src_valid = 1'b0;
    repeat (3) step();
    checks++;
    if ({tx_cnt, fr_cnt, un_cnt, q.size()} !== {32'(20 + NPIX), 32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL reset_frame_totals: got tx=%0d frame_done=%0d underrun=%0d left=%0d expected %0d 1 0 0",
                         tx_cnt, fr_cnt, un_cnt, q.size(), 20 + NPIX);
    end
  endtask

  initial begin
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    test_reset();
    test_cf_burst();
    test_back_to_back();
    test_priority();
    test_underrun();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
